// File: rtl/branch_predictor_if.sv
// Fetch/resolve signal bundle between the core pipeline and the branch predictor.
// The core drives lookup/update (master); the predictor returns prediction, redirect and stats (slave).
interface branch_predictor_if #(
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_branch;
  logic              upd_uncond;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_is_branch, upd_uncond, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_is_branch, upd_uncond, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, RF-stage check and retraining.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic              uncond_q [ENTRIES];

  logic              rp_taken;
  logic [ADDR_W-1:0] rp_target;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, lk_taken, up_hit;
  logic [ADDR_W-1:0] lk_target;
  logic              mp;
  logic [ADDR_W-1:0] redirect;

  // pc[1:0] never participates in index or tag
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

  assign lk_idx    = bp.lookup_pc[IDX_W+1:2];
  assign lk_tag    = bp.lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
  assign lk_target = lk_taken ? target_q[lk_idx] : bp.lookup_pc + PC_STEP;

  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    mp       = 1'b0;
    redirect = (bp.upd_is_branch && bp.upd_taken) ? bp.upd_target : bp.upd_pc + PC_STEP;
    if (bp.upd_valid) begin
      if (bp.upd_is_branch)
        mp = (bp.upd_taken != rp_taken) || (bp.upd_taken && (bp.upd_target != rp_target));
      else
        mp = rp_taken;
    end
  end

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_target;
  assign bp.mispredict  = mp;
  assign bp.redirect_pc = redirect;

  // A redirect squashes the wrong-path instruction, so it must arrive with no prediction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp_taken  <= 1'b0;
      rp_target <= '0;
    end else if (mp) begin
      rp_taken  <= 1'b0;
      rp_target <= '0;
    end else begin
      rp_taken  <= lk_taken;
      rp_target <= lk_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        uncond_q[i] <= 1'b0;
      end
    end else if (bp.upd_valid) begin
      if (bp.upd_is_branch) begin
        if (up_hit) begin
          if (bp.upd_taken && ctr_q[up_idx] != 2'b11)
            ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          else if (!bp.upd_taken && ctr_q[up_idx] != 2'b00)
            ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
          if (bp.upd_taken)
            target_q[up_idx] <= bp.upd_target;
          uncond_q[up_idx] <= bp.upd_uncond;
        end else if (bp.upd_taken) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= bp.upd_target;
          ctr_q[up_idx]    <= 2'b10;
          uncond_q[up_idx] <= bp.upd_uncond;
        end
      end else if (up_hit) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] n_branches, n_mispredicts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_branches    <= '0;
      n_mispredicts <= '0;
    end else begin
      if (bp.upd_valid && bp.upd_is_branch)
        n_branches <= n_branches + 32'd1;
      if (mp)
        n_mispredicts <= n_mispredicts + 32'd1;
    end
  end

  assign bp.stat_branches    = n_branches;
  assign bp.stat_mispredicts = n_mispredicts;
`else
  assign bp.stat_branches    = '0;
  assign bp.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset/stats sequences,
// and randomized traffic against an array-based reference model.
module tb_branch_predictor;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(AW)) bp ();
  branch_predictor #(.ADDR_W(AW), .ENTRIES(16)) dut (.clk(clk), .reset(reset), .bp(bp));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: tag held as pc>>6, counter as plain integer 0..3
  bit          m_valid [16];
  logic [63:0] m_tag   [16];
  logic [63:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_unc   [16];
  bit          m_rpt;
  logic [63:0] m_rpg;
  int unsigned m_br, m_mp;

  typedef struct {
    logic [63:0] lpc;
    logic        uv;
    logic [63:0] upc;
    logic        br, unc, tk;
    logic [63:0] tgt;
    logic        e_hit, e_tk;
    logic [63:0] e_tgt;
    logic        e_mp;
    logic [63:0] e_rd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef BP_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_unc[i] = 0;
    end
    m_rpt = 0; m_rpg = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % 64'd16);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic void m_lookup(input logic [63:0] pc, output bit hit, output bit tk,
                                   output logic [63:0] tg);
    int i = m_idx(pc);
    hit = m_hit(pc);
    tk  = hit && (m_unc[i] || m_ctr[i] >= 2);
    tg  = tk ? m_tgt[i] : pc + 64'd4;
  endfunction

  function automatic void m_check(output bit mp, output logic [63:0] rd);
    mp = 0;
    if (bp.upd_valid)
      mp = bp.upd_is_branch ? ((bp.upd_taken != m_rpt) || (bp.upd_taken && bp.upd_target != m_rpg))
                            : m_rpt;
    rd = (bp.upd_is_branch && bp.upd_taken) ? bp.upd_target : bp.upd_pc + 64'd4;
  endfunction

  function automatic void m_edge();
    bit h, t, mp;
    logic [63:0] g, rd;
    int i;
    m_lookup(bp.lookup_pc, h, t, g);
    m_check(mp, rd);
    if (bp.upd_valid && bp.upd_is_branch) m_br++;
    if (mp) m_mp++;
    i = m_idx(bp.upd_pc);
    if (bp.upd_valid) begin
      if (bp.upd_is_branch) begin
        if (m_hit(bp.upd_pc)) begin
          m_ctr[i] = bp.upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          if (bp.upd_taken) m_tgt[i] = bp.upd_target;
          m_unc[i] = bp.upd_uncond;
        end else if (bp.upd_taken) begin
          m_valid[i] = 1; m_tag[i] = bp.upd_pc >> 6; m_tgt[i] = bp.upd_target;
          m_ctr[i] = 2; m_unc[i] = bp.upd_uncond;
        end
      end else if (m_hit(bp.upd_pc)) begin
        m_valid[i] = 0;
      end
    end
    m_rpt = mp ? 1'b0 : t;
    m_rpg = mp ? 64'd0 : g;
  endfunction

  task automatic drive(input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                       input logic br, input logic unc, input logic tk, input logic [63:0] tgt);
    bp.lookup_pc = lpc; bp.upd_valid = uv; bp.upd_pc = upc; bp.upd_is_branch = br;
    bp.upd_uncond = unc; bp.upd_taken = tk; bp.upd_target = tgt;
  endtask

  task automatic add(input logic [63:0] lpc, input logic uv, input logic [63:0] upc,
                     input logic br, input logic unc, input logic tk, input logic [63:0] tgt,
                     input logic eh, input logic et, input logic [63:0] eg,
                     input logic emp, input logic [63:0] erd);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.br = br; v.unc = unc; v.tk = tk; v.tgt = tgt;
    v.e_hit = eh; v.e_tk = et; v.e_tgt = eg; v.e_mp = emp; v.e_rd = erd;
    vecs.push_back(v);
  endtask

  // one model-checked cycle: outputs compared at the negedge, model advanced, then the edge
  task automatic step(input string nm);
    bit h, t, mp;
    logic [63:0] g, rd;
    @(negedge clk);
    m_lookup(bp.lookup_pc, h, t, g);
    m_check(mp, rd);
    chk({nm, " pred_hit"}, {63'd0, bp.pred_hit}, {63'd0, h});
    chk({nm, " pred_taken"}, {63'd0, bp.pred_taken}, {63'd0, t});
    chk({nm, " pred_target"}, bp.pred_target, g);
    chk({nm, " mispredict"}, {63'd0, bp.mispredict}, {63'd0, mp});
    if (bp.upd_valid) chk({nm, " redirect_pc"}, bp.redirect_pc, rd);
    chk({nm, " stat_branches"}, {32'd0, bp.stat_branches}, {32'd0, exp_stat(m_br)});
    chk({nm, " stat_mispredicts"}, {32'd0, bp.stat_mispredicts}, {32'd0, exp_stat(m_mp)});
    m_edge();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] pc;
    pc = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2) |
         64'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) pc = ~64'd0 - 64'($urandom_range(0, 63));
    return pc;
  endfunction

  function automatic logic [63:0] rand_tgt();
    case ($urandom_range(0, 3))
      0: return 64'h80;
      1: return 64'h1000;
      2: return 64'h2000;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  localparam logic [63:0] ALL1 = ~64'd0;

  initial begin
    logic [63:0] lp, up;
    logic br, unc, tk;
    drive(64'h100, 0, 0, 0, 0, 0, 0);
    m_reset();

    //  lookup  uv upc     br unc tk tgt       hit tk tgt     mp redirect
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    0, 0, 64'h104,  0, 64'h0);
    add(64'h200, 1, 64'h100, 1, 0, 1, 64'h80,   0, 0, 64'h204,  1, 64'h80);
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    1, 1, 64'h80,   0, 64'h0);
    add(64'h100, 1, 64'h100, 1, 0, 0, 64'h0,    1, 1, 64'h80,   1, 64'h104);
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    1, 0, 64'h104,  0, 64'h0);
    add(64'h100, 1, 64'h100, 1, 0, 1, 64'h80,   1, 0, 64'h104,  1, 64'h80);
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    1, 1, 64'h80,   0, 64'h0);
    for (int k = 0; k < 5; k++)
      add(64'h100, 1, 64'h100, 1, 0, 1, 64'h80, 1, 1, 64'h80,   0, 64'h80);
    add(64'h100, 1, 64'h100, 1, 0, 0, 64'h0,    1, 1, 64'h80,   1, 64'h104);
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    1, 1, 64'h80,   0, 64'h0);
    add(64'h500, 1, 64'h100, 0, 0, 0, 64'h0,    0, 0, 64'h504,  1, 64'h104);
    add(64'h100, 0, 64'h0,   0, 0, 0, 64'h0,    0, 0, 64'h104,  0, 64'h0);
    add(ALL1,    1, ALL1,    0, 0, 0, 64'h0,    0, 0, 64'h3,    0, 64'h3);
    add(64'h300, 1, 64'h300, 1, 0, 0, 64'h0,    0, 0, 64'h304,  0, 64'h304);
    add(64'h340, 1, 64'h340, 1, 1, 1, 64'h1000, 0, 0, 64'h344,  1, 64'h1000);
    add(64'h340, 0, 64'h0,   0, 0, 0, 64'h0,    1, 1, 64'h1000, 0, 64'h0);

    #12 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].br, vecs[i].unc, vecs[i].tk, vecs[i].tgt);
      @(negedge clk);
      chk($sformatf("vec%0d pred_hit", i), {63'd0, bp.pred_hit}, {63'd0, vecs[i].e_hit});
      chk($sformatf("vec%0d pred_taken", i), {63'd0, bp.pred_taken}, {63'd0, vecs[i].e_tk});
      chk($sformatf("vec%0d pred_target", i), bp.pred_target, vecs[i].e_tgt);
      chk($sformatf("vec%0d mispredict", i), {63'd0, bp.mispredict}, {63'd0, vecs[i].e_mp});
      if (vecs[i].uv) chk($sformatf("vec%0d redirect_pc", i), bp.redirect_pc, vecs[i].e_rd);
      chk($sformatf("vec%0d stat_branches", i), {32'd0, bp.stat_branches}, {32'd0, exp_stat(m_br)});
      chk($sformatf("vec%0d stat_mispredicts", i), {32'd0, bp.stat_mispredicts},
          {32'd0, exp_stat(m_mp)});
      m_edge();
      @(posedge clk); #1;
    end

    // mid-run reset: clears at once and blocks the write at the edge it spans
    #2 reset = 1'b0;
    m_reset();
    drive(64'h340, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst pred_hit", {63'd0, bp.pred_hit}, 64'd0);
    chk("rst pred_taken", {63'd0, bp.pred_taken}, 64'd0);
    chk("rst pred_target", bp.pred_target, 64'h344);
    chk("rst mispredict", {63'd0, bp.mispredict}, 64'd0);
    chk("rst stat_branches", {32'd0, bp.stat_branches}, 64'd0);
    chk("rst stat_mispredicts", {32'd0, bp.stat_mispredicts}, 64'd0);
    drive(64'h100, 1, 64'h100, 1, 0, 1, 64'h80);
    @(posedge clk); #3;
    drive(64'h100, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post-rst pred_hit", {63'd0, bp.pred_hit}, 64'd0);
    chk("post-rst pred_taken", {63'd0, bp.pred_taken}, 64'd0);
    chk("post-rst pred_target", bp.pred_target, 64'h104);
    chk("post-rst mispredict", {63'd0, bp.mispredict}, 64'd0);
    @(posedge clk); #1;
    m_rpt = 0; m_rpg = 64'h104;

    // three resolved branches, one of them mispredicted
    drive(64'h100, 1, 64'h100, 1, 0, 0, 0);    step("stats a");
    drive(64'h100, 1, 64'h100, 1, 0, 0, 0);    step("stats b");
    drive(64'h100, 1, 64'h100, 1, 0, 1, 64'h80); step("stats c");
    drive(64'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stats branches=3", {32'd0, bp.stat_branches}, {32'd0, exp_stat(3)});
    chk("stats mispredicts=1", {32'd0, bp.stat_mispredicts}, {32'd0, exp_stat(1)});
    @(posedge clk); #1;
    m_edge();

    lp = 64'h100;
    for (int n = 0; n < 3000; n++) begin
      up  = ($urandom_range(0, 1) == 0) ? lp : rand_pc();
      lp  = rand_pc();
      br  = $urandom_range(0, 2) != 0;
      unc = br && ($urandom_range(0, 3) == 0);
      tk  = unc ? 1'b1 : 1'($urandom_range(0, 1));
      drive(lp, $urandom_range(0, 4) != 0, up, br, unc, tk, rand_tgt());
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined AArch64 core. It replaces the current always-not-taken fetch policy, where branches resolve in RF and the PC mux picks PC+4 or the RF-computed target. Lookup is combinational in IF. The prediction is registered into RF alongside the instruction, then checked against the RF-stage branch resolution. On a wrong guess the block raises a mispredict with the correct redirect PC and retrains itself.

## Interface
- ADDR_W, 64: PC width; must be ≥ IDX_W+3.
- ENTRIES, 16: table depth; power of 2, 2..256. IDX_W = log2(ENTRIES); TAG_W = ADDR_W-IDX_W-2.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low; all state cleared while low.
- lookup_pc  in  ADDR_W: IF-stage PC.
- pred_hit  out  1: valid entry with matching tag.
- pred_taken  out  1: predicted taken.
- pred_target  out  ADDR_W: next fetch PC, equal to the entry target if pred_taken, else lookup_pc+4.
- upd_valid  in  1: a valid (non-squashed) instruction is in RF this cycle.
- upd_pc  in  ADDR_W: PC of the RF instruction.
- upd_is_branch  in  1: RF instruction is B, B.cond or CBZ.
- upd_uncond  in  1: RF instruction is unconditional (B).
- upd_taken  in  1: resolved direction.
- upd_target  in  ADDR_W: resolved taken target.
- mispredict  out  1: redirect required.
- redirect_pc  out  ADDR_W: correct next PC, equal to upd_target if upd_taken, else upd_pc+4.
- stat_branches  out  32: resolved-branch count.
- stat_mispredicts  out  32: mispredict count.

## Operation
- Entry fields: valid, tag, target[ADDR_W], ctr[2], uncond.
- Index is pc[IDX_W+1:2]; tag is pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (uncond || ctr[1]).
- Prediction register rp_taken, rp_target:
  - Loads pred_taken/pred_target every edge.
  - Loads 0/0 on any edge where mispredict=1, so the squashed wrong-path instruction carries no prediction.
- Check (combinational, gated by upd_valid):
  - Branch: mispredict = (upd_taken != rp_taken) || (upd_taken && upd_target != rp_target).
  - Non-branch: mispredict = rp_taken; redirect_pc = upd_pc+4.
- Training, at the edge when upd_valid=1:
  - Branch, hit at upd_pc:
    - ctr += 1 if taken, saturating at 11; ctr -= 1 if not taken, saturating at 00.
    - If taken, target <= upd_target.
    - uncond <= upd_uncond.
  - Branch, miss, taken: allocate with valid=1, tag, target=upd_target, ctr=10, uncond=upd_uncond. Any entry at that index is overwritten.
  - Branch, miss, not taken: no write.
  - Non-branch, hit: valid <= 0 (alias eviction).
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. The write lands at the edge.
- Arithmetic: +4 is modulo 2^ADDR_W; the wrap from all-ones to 3 is legal.

## Timing
- Lookup: 0 cycles, pure combinational from lookup_pc and table state.
- Prediction to check: 1 cycle. The prediction made in cycle N is checked against upd_* in cycle N+1.
- mispredict and redirect_pc: combinational from upd_* and rp_*. They are valid the same cycle upd_valid is high; the core's PC mux takes redirect_pc at the next edge.
- Table update becomes visible to lookup the cycle after upd_valid.
- Reset values:
  - All valid=0, ctr=01, rp_taken=0, rp_target=0, stat counters=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, mispredict=0.
- Reset asserted mid-operation: the table and prediction register clear immediately, with no write at the next edge.
- upd_valid=0 (bubble): no training and mispredict=0. rp_* still reloads from lookup.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each edge with upd_valid && upd_is_branch.
  - stat_mispredicts increments on each edge with mispredict=1.
  - Both wrap modulo 2^32.
- BP_STATS_EN undefined: the counters are not instantiated and both stat outputs are tied to 0. Prediction behaviour is identical in both builds.

## Test plan
All scenarios use ENTRIES=16 and ADDR_W=64.
- Reset:
  - Stimulus: reset low mid-run, then release; lookup_pc=0x100.
  - Required: pred_hit=0, pred_taken=0, pred_target=0x104, mispredict=0, stats=0.
- Cold taken branch:
  - Stimulus: upd at 0x100, is_branch=1, taken=1, target=0x80, rp_taken=0.
  - Required: mispredict=1, redirect_pc=0x80.
  - Next cycle: lookup 0x100 gives hit=1, pred_taken=1, pred_target=0x80. rp_* is cleared after the mispredict edge.
- Hysteresis:
  - Stimulus: allocated entry (ctr=10), then one not-taken resolve of 0x100.
  - Required: mispredict=1, redirect_pc=0x104, ctr=01, and the next lookup predicts not-taken.
  - Then one taken resolve: ctr=10 and the next lookup predicts taken.
- Saturation:
  - Stimulus: five consecutive taken resolves of 0x100, then one not-taken.
  - Required: ctr=11 before, ctr=10 after; the prediction stays taken.
- Alias:
  - Stimulus: 0x100 allocated; lookup 0x500 (same index 0, different tag).
  - Required: hit=0, pred_target=0x504.
  - Stimulus: non-branch at 0x100 while its prediction is taken.
  - Required: mispredict=1, redirect_pc=0x104, and the entry is invalidated.
- Stats, with BP_STATS_EN defined:
  - Stimulus: 3 branches with 1 mispredict.
  - Required: stat_branches=3, stat_mispredicts=1.
  - Without the macro: both read 0.
